timesync_master: RTL

Time-sync master for the pulse/latch synchronisation network. It drives the `timesync_pulse` toggle line and the `timesync_latch` line that every time-sync receiver samples, and records its own 64-bit time at each pulse edge. On host command it freezes one pulse edge and returns that edge's master time, which the host then distributes as the SYNC_TIME argument. It sits on the shared command bus beside the other command handlers.

---
 rtl/timesync_master_pkg.sv | 32 +++
 rtl/timesync_period_gen.sv | 43 ++++
 rtl/timesync_master.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/timesync_master_pkg.sv
// Shared definitions for the time-sync master: command/response codes, timing defaults
// and the control FSM state encoding.
package timesync_master_pkg;

   localparam int unsigned     DEF_CMD_BITS       = 8;
   localparam logic [7:0]      DEF_CMD_TS_START   = 8'h30;
   localparam logic [7:0]      DEF_CMD_TS_LATCH   = 8'h31;
   localparam logic [7:0]      DEF_CMD_TS_RELEASE = 8'h32;
   localparam logic [31:0]     DEF_RSP_TS_LATCH   = 32'h0000_00B1;
   localparam int unsigned     DEF_MIN_PERIOD     = 16;
   localparam int unsigned     DEF_LATCH_DELAY    = 4;

   typedef enum logic [2:0] {
      StIdle,
      StStart1,
      StLatchWait,
      StLatchDly,
      StRspLo,
      StRspHi,
      StRspEnd
   } ts_state_e;

   // Zero keeps the generator stopped; any other value below the floor is raised to it.
   function automatic logic [31:0] clamp_period(input logic [31:0] arg,
                                                input int unsigned min_period);
      if (arg != 32'd0 && arg < min_period) begin
         return 32'(min_period);
      end
      return arg;
   endfunction

endpackage

// File: rtl/timesync_period_gen.sv
// Pulse period generator: down-counter with clamped reload and a one-shot force input.
// toggle_o is a single-cycle strobe in the cycle the pulse line should flip.
module timesync_period_gen
   import timesync_master_pkg::*;
#(
   parameter int unsigned MIN_PERIOD = DEF_MIN_PERIOD
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_i,
   input  logic [31:0] load_arg_i,
   input  logic        force_i,
   output logic        toggle_o,
   output logic        running_o
);

   logic [31:0] period_q, period_d;
   logic [31:0] cnt_q, cnt_d;

   always_comb begin
      running_o = (period_q != 32'd0);
      toggle_o  = force_i | (running_o & (cnt_q == 32'd0));
      period_d  = period_q;
      cnt_d     = cnt_q;
      if (load_i) begin
         period_d = clamp_period(load_arg_i, MIN_PERIOD);
         cnt_d    = period_d - 32'd1;
      end else if (running_o) begin
         cnt_d = (cnt_q == 32'd0) ? period_q - 32'd1 : cnt_q - 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         period_q <= 32'd0;
         cnt_q    <= 32'd0;
      end else begin
         period_q <= period_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/timesync_master.sv
// Time-sync master: drives the pulse/latch lines, records the master time at each pulse
// edge and returns the frozen edge time to the host as two response words.
module timesync_master
   import timesync_master_pkg::*;
#(
   parameter int unsigned         CMD_BITS       = DEF_CMD_BITS,
   parameter logic [CMD_BITS-1:0] CMD_TS_START   = CMD_BITS'(DEF_CMD_TS_START),
   parameter logic [CMD_BITS-1:0] CMD_TS_LATCH   = CMD_BITS'(DEF_CMD_TS_LATCH),
   parameter logic [CMD_BITS-1:0] CMD_TS_RELEASE = CMD_BITS'(DEF_CMD_TS_RELEASE),
   parameter logic [31:0]         RSP_TS_LATCH   = DEF_RSP_TS_LATCH,
   parameter int unsigned         MIN_PERIOD     = DEF_MIN_PERIOD,
   parameter int unsigned         LATCH_DELAY    = DEF_LATCH_DELAY
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [63:0]         time_in,
   input  logic [31:0]         arg_data,
   output logic                arg_advance,
   input  logic [CMD_BITS-1:0] cmd,
   input  logic                cmd_ready,
   output logic                cmd_done,
   output logic [31:0]         param_data,
   output logic                param_write,
   output logic                timesync_pulse_out,
   output logic                timesync_latch_out
);

   localparam logic [7:0] DLY_INIT = 8'(LATCH_DELAY - 1);

   ts_state_e   state_q, state_d;
   logic [63:0] edge_time_q, edge_time_d;
   logic        frozen_q, frozen_d;
   logic [7:0]  dly_q, dly_d;
   logic        pulse_q, pulse_d;
   logic        latch_q, latch_d;
   logic        done_q, done_d;
   logic        pwrite_q, pwrite_d;
   logic [31:0] pdata_q, pdata_d;

   logic period_load;
   logic force_toggle;
   logic toggle;
   logic running;

   assign period_load  = (state_q == StStart1);
   // A stopped generator would never produce the edge a latch waits for.
   assign force_toggle = (state_q == StLatchWait) && !running;

   timesync_period_gen #(
      .MIN_PERIOD (MIN_PERIOD)
   ) u_period_gen (
      .clk        (clk),
      .rst        (rst),
      .load_i     (period_load),
      .load_arg_i (arg_data),
      .force_i    (force_toggle),
      .toggle_o   (toggle),
      .running_o  (running)
   );

   always_comb begin
      state_d     = state_q;
      frozen_d    = frozen_q;
      dly_d       = dly_q;
      latch_d     = latch_q;
      pdata_d     = pdata_q;
      done_d      = 1'b0;
      pwrite_d    = 1'b0;
      pulse_d     = pulse_q ^ toggle;
      edge_time_d = (toggle && !frozen_q) ? time_in : edge_time_q;

      unique case (state_q)
         StIdle: begin
            if (cmd_ready) begin
               if (cmd == CMD_TS_START) begin
                  state_d = StStart1;
               end else if (cmd == CMD_TS_LATCH) begin
                  if (frozen_q) begin
                     state_d  = StRspLo;
                     pwrite_d = 1'b1;
                     pdata_d  = edge_time_q[31:0];
                  end else begin
                     state_d = StLatchWait;
                  end
               end else if (cmd == CMD_TS_RELEASE) begin
                  latch_d  = 1'b0;
                  frozen_d = 1'b0;
                  done_d   = 1'b1;
               end
            end
         end
         StStart1: begin
            done_d  = 1'b1;
            state_d = StIdle;
         end
         StLatchWait: begin
            if (toggle) begin
               frozen_d = 1'b1;
               dly_d    = DLY_INIT;
               state_d  = StLatchDly;
            end
         end
         StLatchDly: begin
            if (dly_q == 8'd0) begin
               latch_d  = 1'b1;
               pwrite_d = 1'b1;
               pdata_d  = edge_time_q[31:0];
               state_d  = StRspLo;
            end else begin
               dly_d = dly_q - 8'd1;
            end
         end
         StRspLo: begin
            pwrite_d = 1'b1;
            pdata_d  = edge_time_q[63:32];
            state_d  = StRspHi;
         end
         StRspHi: begin
            pdata_d = RSP_TS_LATCH;
            done_d  = 1'b1;
            state_d = StRspEnd;
         end
         StRspEnd: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         edge_time_q <= 64'd0;
         frozen_q    <= 1'b0;
         dly_q       <= 8'd0;
         pulse_q     <= 1'b0;
         latch_q     <= 1'b0;
         done_q      <= 1'b0;
         pwrite_q    <= 1'b0;
         pdata_q     <= 32'd0;
      end else begin
         state_q     <= state_d;
         edge_time_q <= edge_time_d;
         frozen_q    <= frozen_d;
         dly_q       <= dly_d;
         pulse_q     <= pulse_d;
         latch_q     <= latch_d;
         done_q      <= done_d;
         pwrite_q    <= pwrite_d;
         pdata_q     <= pdata_d;
      end
   end

   assign arg_advance        = 1'b1;
   assign cmd_done           = done_q;
   assign param_write        = pwrite_q;
   assign param_data         = pdata_q;
   assign timesync_pulse_out = pulse_q;
   assign timesync_latch_out = latch_q;

endmodule
